// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package imem_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 15'h0000;

    // One buffered fetch: the instruction word and the byte address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } fetch_entry_t;

    // Force a byte address onto a 4-byte instruction boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, inst} entries sitting between memory return and decode.
// Latency: a push is visible at the head the cycle after; head is read straight from storage.
// Backpressure: pushes beyond DEPTH are ignored unless a pop frees a slot the same cycle; flush empties it.
//
// Ports: clk/reset (sync, active-high); push/push_entry write the tail;
//        pop consumes the head; flush discards all entries; head/count report state.
module fetch_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: issues one word fetch per cycle, buffers returns, hands them to decode.
// Latency: issue in cycle t is presented with out_valid in cycle t+MEM_LAT+1; redirect target at r+MEM_LAT+2.
// Backpressure: issue stalls while buffered + in-flight fetches would exceed DEPTH; nothing is dropped.
//
// Ports: clk/reset (sync, active-high); imem_req/imem_addr/imem_data to the memory;
//        redirect_valid/redirect_pc from branch resolution; out_valid/out_ready/out_inst/out_pc
//        to decode; align_err is a sticky flag for misaligned redirect targets.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int                MEM_LAT  = 0,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = imem_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              align_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic              epoch;
    logic [CW-1:0]     count;
    logic [4:0]        inflight;
    logic [4:0]        occupancy;

    logic              ret_vld;
    logic              ret_ep;
    logic [ADDR_W-1:0] ret_pc;

    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Pops are deliberately not credited here: space is only reused once it is actually free.
    assign occupancy = 5'(count) + inflight;
    assign imem_req  = !reset && !redirect_valid && (occupancy < 5'(DEPTH));
    assign imem_addr = fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            epoch     <= 1'b0;
            align_err <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= word_align(redirect_pc);
            epoch    <= ~epoch;
            if (redirect_pc[1:0] != 2'b00) begin
                align_err <= 1'b1;
            end
        end else if (imem_req) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    generate
        if (MEM_LAT == 0) begin : g_comb_mem
            // Combinational memory: the word for this cycle's issue is already on imem_data.
            assign ret_vld  = imem_req;
            assign ret_pc   = fetch_pc;
            assign ret_ep   = epoch;
            assign inflight = '0;
        end else begin : g_tracker
            logic [MEM_LAT-1:0] trk_vld;
            logic [MEM_LAT-1:0] trk_ep;
            logic [ADDR_W-1:0]  trk_pc [MEM_LAT];

            always_ff @(posedge clk) begin
                if (reset) begin
                    trk_vld <= '0;
                    trk_ep  <= '0;
                    for (int i = 0; i < MEM_LAT; i++) begin
                        trk_pc[i] <= '0;
                    end
                end else begin
                    trk_vld[0] <= imem_req;
                    trk_ep[0]  <= epoch;
                    trk_pc[0]  <= fetch_pc;
                    for (int i = 1; i < MEM_LAT; i++) begin
                        trk_vld[i] <= trk_vld[i-1];
                        trk_ep[i]  <= trk_ep[i-1];
                        trk_pc[i]  <= trk_pc[i-1];
                    end
                end
            end

            // Stale-epoch fetches will be dropped, so they do not reserve buffer space.
            // This lets the redirect target issue the very next cycle.
            always_comb begin
                inflight = '0;
                for (int i = 0; i < MEM_LAT; i++) begin
                    if (trk_vld[i] && (trk_ep[i] == epoch)) begin
                        inflight = inflight + 5'd1;
                    end
                end
            end

            assign ret_vld = trk_vld[MEM_LAT-1];
            assign ret_pc  = trk_pc[MEM_LAT-1];
            assign ret_ep  = trk_ep[MEM_LAT-1];
        end
    endgenerate

    // A redirect outranks any return landing in the same cycle.
    assign push       = ret_vld && (ret_ep == epoch) && !redirect_valid;
    assign push_entry = '{pc: ret_pc, inst: imem_data};
    assign pop        = out_valid && out_ready;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    assign out_valid = (count != '0);
    assign out_inst  = head.inst;
    assign out_pc    = head.pc;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
    import imem_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: combinational memory, 2-entry buffer
    logic              rst_a, req_a, rv_a, ov_a, ordy_a, aerr_a;
    logic [ADDR_W-1:0] addr_a, rpc_a, opc_a;
    logic [DATA_W-1:0] data_a, inst_a;

    // Instance B: two-cycle memory, 4-entry buffer
    logic              rst_b, req_b, rv_b, ov_b, ordy_b, aerr_b;
    logic [ADDR_W-1:0] addr_b, rpc_b, opc_b;
    logic [DATA_W-1:0] data_b, inst_b;
    logic [ADDR_W-1:0] bd1, bd2;

    fetch_entry_t exp_a[$];
    fetch_entry_t exp_b[$];
    fetch_entry_t e_a, e_b;

    // Distinct, address-derived memory contents.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {2'b10, a, ~a};
    endfunction

    assign data_a = mem_word(addr_a);

    always @(posedge clk) begin
        bd1 <= addr_b;
        bd2 <= bd1;
    end
    assign data_b = mem_word(bd2);

    imem_fetch_ctrl #(.MEM_LAT(0), .DEPTH(2), .RESET_PC(15'h0000)) dut_a (
        .clk(clk), .reset(rst_a), .imem_req(req_a), .imem_addr(addr_a), .imem_data(data_a),
        .redirect_valid(rv_a), .redirect_pc(rpc_a), .out_valid(ov_a), .out_ready(ordy_a),
        .out_inst(inst_a), .out_pc(opc_a), .align_err(aerr_a)
    );

    imem_fetch_ctrl #(.MEM_LAT(2), .DEPTH(4), .RESET_PC(15'h0000)) dut_b (
        .clk(clk), .reset(rst_b), .imem_req(req_b), .imem_addr(addr_b), .imem_data(data_b),
        .redirect_valid(rv_b), .redirect_pc(rpc_b), .out_valid(ov_b), .out_ready(ordy_b),
        .out_inst(inst_b), .out_pc(opc_b), .align_err(aerr_b)
    );

    // Scoreboards: every completed handshake must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_a && ov_a && ordy_a) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $error("FAIL sb_a: observed unexpected pc=%h, required no output", opc_a);
            end else begin
                e_a = exp_a.pop_front();
                assert ({opc_a, inst_a} === e_a) else begin
                    errors++;
                    $error("FAIL sb_a: observed pc=%h inst=%h required pc=%h inst=%h",
                           opc_a, inst_a, e_a.pc, e_a.inst);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && ov_b && ordy_b) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $error("FAIL sb_b: observed unexpected pc=%h, required no output", opc_b);
            end else begin
                e_b = exp_b.pop_front();
                assert ({opc_b, inst_b} === e_b) else begin
                    errors++;
                    $error("FAIL sb_b: observed pc=%h inst=%h required pc=%h inst=%h",
                           opc_b, inst_b, e_b.pc, e_b.inst);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Replace the expected stream with sequential fetches starting at 'start'.
    task automatic sb_fill(input bit which_b, input logic [ADDR_W-1:0] start);
        logic [ADDR_W-1:0] pc;
        pc = start;
        if (which_b) exp_b.delete();
        else         exp_a.delete();
        for (int k = 0; k < 48; k++) begin
            if (which_b) exp_b.push_back('{pc: pc, inst: mem_word(pc)});
            else         exp_a.push_back('{pc: pc, inst: mem_word(pc)});
            pc = pc + 15'd4;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic chk_reset_a(input string pfx);
        chk({pfx, "_req"},   32'(req_a),  32'd0);
        chk({pfx, "_addr"},  32'(addr_a), 32'h0000);
        chk({pfx, "_vld"},   32'(ov_a),   32'd0);
        chk({pfx, "_inst"},  inst_a,      32'd0);
        chk({pfx, "_pc"},    32'(opc_a),  32'd0);
        chk({pfx, "_align"}, 32'(aerr_a), 32'd0);
    endtask

    initial begin
        logic [ADDR_W-1:0] wpc;
        rst_a = 1'b1; rv_a = 1'b0; rpc_a = '0; ordy_a = 1'b0;
        rst_b = 1'b1; rv_b = 1'b0; rpc_b = '0; ordy_b = 1'b0;

        // ---- A: reset values
        repeat (3) cyc();
        smp();
        chk_reset_a("rst");

        // ---- A: stream from RESET_PC, one per cycle from cycle 1
        cyc(); rst_a = 1'b0; ordy_a = 1'b1; sb_fill(1'b0, 15'h0000);   // cycle 0
        smp();
        chk("c0_req",  32'(req_a),  32'd1);
        chk("c0_addr", 32'(addr_a), 32'h0000);
        for (int k = 1; k <= 4; k++) begin
            cyc(); smp();
            chk("stream_vld", 32'(ov_a),  32'd1);
            chk("stream_pc",  32'(opc_a), 32'(4 * (k - 1)));
        end

        // ---- A: stall for 5 cycles, buffer fills to DEPTH and issue stops
        cyc(); ordy_a = 1'b0; smp();                                   // cycle 5
        chk("stall_pc", 32'(opc_a), 32'h10);
        for (int k = 6; k <= 9; k++) begin
            cyc(); smp();
            chk("stall_req",  32'(req_a), 32'd0);
            chk("stall_vld",  32'(ov_a),  32'd1);
            chk("stall_hold", 32'(opc_a), 32'h10);
        end
        cyc(); ordy_a = 1'b1; smp();                                   // cycle 10
        chk("drain_pc", 32'(opc_a), 32'h10);
        for (int k = 11; k <= 13; k++) begin
            cyc(); smp();
            chk("drain_vld", 32'(ov_a),  32'd1);
            chk("drain_pc",  32'(opc_a), 32'(16 + 4 * (k - 10)));
        end

        // ---- A: redirect with two buffered entries and decode accepting
        cyc(); ordy_a = 1'b0; smp();                                   // cycle 14
        cyc(); smp();                                                  // cycle 15
        chk("full_req",  32'(req_a), 32'd0);
        chk("full_head", 32'(opc_a), 32'h20);
        cyc(); rv_a = 1'b1; rpc_a = 15'h0100; ordy_a = 1'b1; smp();    // cycle 16 = r
        chk("redir_req",  32'(req_a), 32'd0);
        chk("redir_head", 32'(opc_a), 32'h20);
        cyc(); rv_a = 1'b0; sb_fill(1'b0, 15'h0100); smp();            // r+1
        chk("flush_vld",  32'(ov_a),   32'd0);
        chk("tgt_req",    32'(req_a),  32'd1);
        chk("tgt_addr",   32'(addr_a), 32'h0100);
        cyc(); smp();                                                  // r+2
        chk("tgt_vld", 32'(ov_a),  32'd1);
        chk("tgt_pc",  32'(opc_a), 32'h0100);
        repeat (2) cyc();

        // ---- A: address wrap at the top of memory
        cyc(); rv_a = 1'b1; rpc_a = 15'h7FF8; smp();
        cyc(); rv_a = 1'b0; sb_fill(1'b0, 15'h7FF8);
        wpc = 15'h7FF8;
        for (int k = 0; k < 3; k++) begin
            cyc(); smp();
            chk("wrap_pc", 32'(opc_a), 32'(wpc));
            wpc = wpc + 15'd4;
        end
        chk("align_pre", 32'(aerr_a), 32'd0);

        // ---- A: misaligned redirect
        cyc(); rv_a = 1'b1; rpc_a = 15'h0102; smp();
        chk("mis_req", 32'(req_a), 32'd0);
        cyc(); rv_a = 1'b0; sb_fill(1'b0, 15'h0100); smp();
        chk("mis_addr",  32'(addr_a), 32'h0100);
        chk("mis_req1",  32'(req_a),  32'd1);
        chk("mis_align", 32'(aerr_a), 32'd1);
        cyc(); smp();
        chk("mis_pc", 32'(opc_a), 32'h0100);
        repeat (3) cyc();
        smp();
        chk("align_hold", 32'(aerr_a), 32'd1);

        // ---- A: reset mid-stream
        cyc(); rst_a = 1'b1;
        cyc(); smp();
        chk_reset_a("mrst");
        cyc(); rst_a = 1'b0; sb_fill(1'b0, 15'h0000); smp();
        chk("refetch_req",  32'(req_a),  32'd1);
        chk("refetch_addr", 32'(addr_a), 32'h0000);
        cyc(); smp();
        chk("refetch_vld", 32'(ov_a),  32'd1);
        chk("refetch_pc",  32'(opc_a), 32'h0000);
        cyc(); rst_a = 1'b1;

        // ---- B: MEM_LAT=2, DEPTH=4 latency and sustained throughput
        cyc(); rst_b = 1'b0; ordy_b = 1'b1; sb_fill(1'b1, 15'h0000); smp();   // cycle 0
        chk("b_c0_req",  32'(req_b),  32'd1);
        chk("b_c0_addr", 32'(addr_b), 32'h0000);
        for (int k = 1; k <= 2; k++) begin
            cyc(); smp();
            chk("b_lat_vld", 32'(ov_b), 32'd0);
        end
        for (int k = 3; k <= 7; k++) begin
            cyc(); smp();
            chk("b_tp_vld", 32'(ov_b),  32'd1);
            chk("b_tp_pc",  32'(opc_b), 32'(4 * (k - 3)));
            chk("b_tp_req", 32'(req_b), 32'd1);
        end

        // ---- B: redirect with two fetches in flight
        cyc(); rv_b = 1'b1; rpc_b = 15'h0200; smp();                   // cycle 8 = r
        chk("b_redir_req", 32'(req_b), 32'd0);
        cyc(); rv_b = 1'b0; sb_fill(1'b1, 15'h0200); smp();            // r+1
        chk("b_stale_vld", 32'(ov_b), 32'd0);
        for (int k = 2; k <= 3; k++) begin
            cyc(); smp();
            chk("b_stale_vld", 32'(ov_b), 32'd0);
        end
        cyc(); smp();                                                  // r+4
        chk("b_tgt_vld", 32'(ov_b),  32'd1);
        chk("b_tgt_pc",  32'(opc_b), 32'h0200);

        // ---- B: stall fills all four entries without loss
        cyc();
        cyc(); ordy_b = 1'b0;
        repeat (5) cyc();
        smp();
        chk("b_full_req", 32'(req_b), 32'd0);
        chk("b_full_vld", 32'(ov_b),  32'd1);
        chk("b_hold_pc",  32'(opc_b), 32'h0208);
        cyc(); ordy_b = 1'b1;
        repeat (8) cyc();
        smp();
        chk("b_resume_vld", 32'(ov_b), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller between the PC logic and the byte-addressed instruction memory, which has a 15-bit address and returns a 32-bit big-endian word. It issues one word fetch per cycle and buffers returned words with their PC in a small FIFO. It presents them to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and discard any fetches still in flight.

## Interface
- ADDR_W, 15, byte address width (32 KiB memory)
- DATA_W, 32, instruction width
- MEM_LAT, 0, cycles from imem_addr to valid imem_data (0..3; 0 = combinational memory)
- DEPTH, 2, FIFO entries (2..8)
- RESET_PC, 15'h0000, first fetch address after reset
---
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch issued this cycle
- imem_addr  out  ADDR_W  fetch address, word-aligned ([1:0]=0)
- imem_data  in  DATA_W  word for the address issued MEM_LAT cycles earlier
- redirect_valid  in  1  branch/jump taken
- redirect_pc  in  ADDR_W  new fetch target
- out_valid  out  1  out_inst/out_pc valid
- out_ready  in  1  decode accepts
- out_inst  out  DATA_W  instruction word
- out_pc  out  ADDR_W  address of out_inst
- align_err  out  1  sticky; set when redirect_pc[1:0]≠0, cleared only by reset

## Operation
- State: fetch_pc, FIFO (count 0..DEPTH), in-flight tracker (MEM_LAT-stage shift register of {valid, pc, epoch}), and a 1-bit epoch.
- Issue rule: imem_req=1 when no redirect this cycle and count + inflight < DEPTH. Pops in the same cycle are not counted as freed space.
- On issue: imem_addr=fetch_pc; fetch_pc ← fetch_pc+4, modulo 2^15 (0x7FFC wraps to 0x0000).
- Return: when the tracker's output stage is valid and its epoch equals the current epoch, push {pc, imem_data} into the FIFO. Mismatched epochs are dropped.
- Output: out_valid = count≠0. FIFO head drives out_inst/out_pc. Pop when out_valid && out_ready.
- Redirect (redirect_valid=1):
  - fetch_pc ← {redirect_pc[14:2],2'b00}; epoch toggles.
  - FIFO is cleared; imem_req=0 that cycle.
  - If redirect_pc[1:0]≠0, set align_err.
- Simultaneous redirect + pop: the handshake completes (head is consumed by decode), then the FIFO is cleared. Redirect has priority over push.
- Full FIFO with out_ready=0: no issue, no loss; outputs hold stable while out_valid=1 and out_ready=0.
- Reset mid-operation clears the FIFO, tracker, epoch and align_err; fetch_pc ← RESET_PC. In-flight data is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0, align_err=0.
- First issue: in the first cycle with reset low (cycle 0), addr=RESET_PC.
- Latency: an issue in cycle t is pushed at the end of cycle t+MEM_LAT; out_valid appears in cycle t+MEM_LAT+1.
- Throughput: 1 instruction/cycle with out_ready held high requires DEPTH ≥ MEM_LAT+2. With defaults, that is sustained after a 1-cycle fill.
- Redirect penalty: for a redirect in cycle r, the first issue of the target is in cycle r+1. The target instruction appears with out_valid in cycle r+MEM_LAT+2.
- Output is registered: out_* come straight from FIFO storage, with no combinational path from imem_data.

## Structure
- Package imem_pkg:
  - ADDR_W, DATA_W, RESET_PC
  - fetch_entry_t struct {pc, inst}
  - word_align() function
- Sub-module fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, and synchronous reset.
- The controller holds the PC, the epoch/in-flight tracker and the issue logic.

## Test plan
- Reset, then out_ready=1, default params, memory holding words W0..W3 at 0,4,8,12 → out_pc 0,4,8,12 on consecutive cycles from cycle 1, out_inst matching W0..W3.
- out_ready=0 for 5 cycles → exactly DEPTH entries buffered, imem_req=0 once full. Release → same ordered sequence with no gaps, drops or duplicates.
- Redirect to 0x0100 while the FIFO holds 2 entries and out_ready=1 → head accepted that cycle, remaining entry gone. Next out_pc=0x0100 at r+2.
- MEM_LAT=2, DEPTH=4, redirect while 2 fetches are in flight → stale returns dropped, no stale out_pc ever valid.
- Fetch from 0x7FF8 → out_pc 0x7FF8, 0x7FFC, 0x0000.
- Redirect to 0x0102 → fetch at 0x0100 and align_err=1 held. Assert reset mid-stream → next cycle all outputs at reset values, then refetch from RESET_PC.
